// File: rtl/fpga.sv
// ---------------------------------------------------------------------------
// fpga : shared single-wire serial bus with 16 transmitting nodes.
//
// A fixed-priority arbiter (node 1 highest) picks one requesting node per
// frame, snapshots that node's fields and shifts the frame out MSB first on
// the registered bus line. Frame layout, one bit per clock:
//   start(0) | sender N-1 (4) | receiverAddr (4) | Data (64) | CRC (4) |
//   EOF_BITS recessive ones
//
// Ports
//   clock                           system clock, rising edge
//   reset                           asynchronous, active-high reset
//   CRC1..CRC16           [3:0]     CRC nibble carried in node N's frame
//   Data1..Data16         [63:0]    payload of node N
//   receiverAddr1..16     [3:0]     destination address of node N
//   mod                   [15:0]    level request mask, bit N-1 = node N
//   bus_show                        registered bus line, idle level 1
// ---------------------------------------------------------------------------
module fpga #(
    parameter int EOF_BITS = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  CRC1,  CRC2,  CRC3,  CRC4,  CRC5,  CRC6,  CRC7,  CRC8,
    input  logic [3:0]  CRC9,  CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
    input  logic [63:0] Data1,  Data2,  Data3,  Data4,  Data5,  Data6,  Data7,  Data8,
    input  logic [63:0] Data9,  Data10, Data11, Data12, Data13, Data14, Data15, Data16,
    input  logic [3:0]  receiverAddr1,  receiverAddr2,  receiverAddr3,  receiverAddr4,
    input  logic [3:0]  receiverAddr5,  receiverAddr6,  receiverAddr7,  receiverAddr8,
    input  logic [3:0]  receiverAddr9,  receiverAddr10, receiverAddr11, receiverAddr12,
    input  logic [3:0]  receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
    input  logic [15:0] mod,
    output logic        bus_show
);

    localparam int FRAME_BITS = 77 + EOF_BITS;
    // Everything after the start bit is held in a shift register.
    localparam int TAIL_BITS  = FRAME_BITS - 1;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state, next_state;
    logic [CNT_W-1:0]     bit_count, next_count;
    logic [TAIL_BITS-1:0] frame_tail, next_tail;
    logic                 next_bus;
    logic                 grant_slot;
    logic                 any_req;
    logic [3:0]           grant_idx;

    logic [3:0]  crc_arr  [16];
    logic [63:0] data_arr [16];
    logic [3:0]  rx_arr   [16];

    assign crc_arr  = '{CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
                        CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16};
    assign data_arr = '{Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
                        Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16};
    assign rx_arr   = '{receiverAddr1,  receiverAddr2,  receiverAddr3,  receiverAddr4,
                        receiverAddr5,  receiverAddr6,  receiverAddr7,  receiverAddr8,
                        receiverAddr9,  receiverAddr10, receiverAddr11, receiverAddr12,
                        receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16};

    assign any_req = |mod;

    // Fixed-priority encoder: scanning from the top down lets the lowest set
    // request bit overwrite the others, so node 1 always wins.
    always_comb begin
        grant_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mod[i]) begin
                grant_idx = 4'(i);
            end
        end
    end

    // Next-state and next-output logic. The edge that ends the last EOF bit
    // runs the same grant decision as an IDLE edge, so a still-pending
    // request starts its start bit with no dead cycle between frames, and
    // the counter never wraps into a new frame without re-arbitration.
    always_comb begin
        next_state = state;
        next_count = bit_count;
        next_tail  = frame_tail;
        next_bus   = 1'b1;
        grant_slot = 1'b0;

        case (state)
            IDLE: begin
                grant_slot = 1'b1;
            end
            SEND: begin
                if (bit_count == LAST_BIT) begin
                    grant_slot = 1'b1;
                end else begin
                    next_count = bit_count + 1'b1;
                    next_bus   = frame_tail[TAIL_BITS-1];
                    next_tail  = {frame_tail[TAIL_BITS-2:0], 1'b1};
                end
            end
            default: begin
                grant_slot = 1'b1;
            end
        endcase

        if (grant_slot) begin
            next_count = '0;
            if (any_req) begin
                next_state = SEND;
                next_bus   = 1'b0;
                next_tail  = {grant_idx, rx_arr[grant_idx], data_arr[grant_idx],
                              crc_arr[grant_idx], {EOF_BITS{1'b1}}};
            end else begin
                next_state = IDLE;
                next_bus   = 1'b1;
            end
        end
    end

    // State, counter, frame snapshot and the registered bus line. Reset
    // forces the line recessive immediately and abandons any frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_count  <= '0;
            frame_tail <= '0;
            bus_show   <= 1'b1;
        end else begin
            state      <= next_state;
            bit_count  <= next_count;
            frame_tail <= next_tail;
            bus_show   <= next_bus;
        end
    end

endmodule

// File: tb/tb_fpga.sv
// ---------------------------------------------------------------------------
// tb_fpga : self-checking bench for the fpga serial bus block.
// A bit-queue reference model builds each frame from the field rules and
// supplies the expected bus level for every clock.
// ---------------------------------------------------------------------------
module tb_fpga;

    localparam int EOF_BITS = 7;
    localparam int FB       = 77 + EOF_BITS;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  crc  [16];
    logic [63:0] data [16];
    logic [3:0]  rx   [16];
    logic [15:0] mod;
    logic        bus_show;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fpga #(.EOF_BITS(EOF_BITS)) dut (
        .clock(clock), .reset(reset),
        .CRC1(crc[0]),   .CRC2(crc[1]),   .CRC3(crc[2]),   .CRC4(crc[3]),
        .CRC5(crc[4]),   .CRC6(crc[5]),   .CRC7(crc[6]),   .CRC8(crc[7]),
        .CRC9(crc[8]),   .CRC10(crc[9]),  .CRC11(crc[10]), .CRC12(crc[11]),
        .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
        .Data1(data[0]),   .Data2(data[1]),   .Data3(data[2]),   .Data4(data[3]),
        .Data5(data[4]),   .Data6(data[5]),   .Data7(data[6]),   .Data8(data[7]),
        .Data9(data[8]),   .Data10(data[9]),  .Data11(data[10]), .Data12(data[11]),
        .Data13(data[12]), .Data14(data[13]), .Data15(data[14]), .Data16(data[15]),
        .receiverAddr1(rx[0]),   .receiverAddr2(rx[1]),   .receiverAddr3(rx[2]),
        .receiverAddr4(rx[3]),   .receiverAddr5(rx[4]),   .receiverAddr6(rx[5]),
        .receiverAddr7(rx[6]),   .receiverAddr8(rx[7]),   .receiverAddr9(rx[8]),
        .receiverAddr10(rx[9]),  .receiverAddr11(rx[10]), .receiverAddr12(rx[11]),
        .receiverAddr13(rx[12]), .receiverAddr14(rx[13]), .receiverAddr15(rx[14]),
        .receiverAddr16(rx[15]),
        .mod(mod),
        .bus_show(bus_show)
    );

    // Reference model: a queue of bits still to be sent. Whenever the queue
    // is empty at a rising edge and someone requests, the lowest-numbered
    // requester's frame is appended from the current inputs.
    bit exp_bus = 1'b1;
    bit frame_q[$];
    int winner;

    function automatic void load_frame(input int n);
        frame_q.push_back(1'b0);
        for (int b = 3; b >= 0; b--)  frame_q.push_back(n[b]);
        for (int b = 3; b >= 0; b--)  frame_q.push_back(rx[n][b]);
        for (int b = 63; b >= 0; b--) frame_q.push_back(data[n][b]);
        for (int b = 3; b >= 0; b--)  frame_q.push_back(crc[n][b]);
        for (int b = 0; b < EOF_BITS; b++) frame_q.push_back(1'b1);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_q.delete();
            exp_bus = 1'b1;
        end else begin
            if (frame_q.size() == 0 && mod != 16'h0000) begin
                winner = 0;
                for (int i = 15; i >= 0; i--) if (mod[i]) winner = i;
                load_frame(winner);
            end
            if (frame_q.size() != 0) exp_bus = frame_q.pop_front();
            else                     exp_bus = 1'b1;
        end
    end

    logic [FB-1:0] f1, f2;

    task automatic test_reset();
        reset = 1'b1;
        mod   = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            crc[i] = 4'h0; data[i] = 64'h0; rx[i] = 4'h0;
        end
        @(negedge clock);
        total++;
        if (bus_show !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_level: bus_show=%b expected 1", bus_show);
        end
        reset = 1'b0;
        data[0] = 64'h1; rx[0] = 4'h1; crc[0] = 4'h1;
        mod = 16'h0001;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== exp_bus) begin
                bad++; $display("[TB] FAIL pre_reset_frame bit %0d: bus_show=%b expected %b", k, bus_show, exp_bus);
            end
        end
        // Bit 40 is a payload zero; reset must force the line high at once.
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus_show !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_async: bus_show=%b expected 1", bus_show);
        end
        mod = 16'h0000;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== 1'b1) begin
                bad++; $display("[TB] FAIL idle_after_reset cycle %0d: bus_show=%b expected 1", k, bus_show);
            end
        end
    endtask

    task automatic test_single_node();
        logic [FB-1:0] single_exp;
        single_exp = {1'b0, 4'h0, 4'h1, 64'h1, 4'h1, 7'h7F};
        data[0] = 64'h1; rx[0] = 4'h1; crc[0] = 4'h1;
        mod = 16'h0001;
        for (int fr = 0; fr < 2; fr++) begin
            for (int k = 0; k < FB; k++) begin
                @(negedge clock);
                total++;
                if (bus_show !== exp_bus) begin
                    bad++; $display("[TB] FAIL single_node frame %0d bit %0d: bus_show=%b expected %b", fr, k, bus_show, exp_bus);
                end
                f1[FB-1-k] = bus_show;
            end
            total++;
            if (f1 !== single_exp) begin
                bad++; $display("[TB] FAIL single_node_frame %0d: got %h expected %h", fr, f1, single_exp);
            end
        end
        mod = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== 1'b1) begin
                bad++; $display("[TB] FAIL single_node_idle cycle %0d: bus_show=%b expected 1", k, bus_show);
            end
        end
    endtask

    task automatic test_priority();
        data[0] = 64'h0; data[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        rx[0] = 4'($urandom); rx[1] = 4'($urandom);
        mod = 16'h0003;
        for (int fr = 0; fr < 2; fr++) begin
            for (int k = 0; k < FB; k++) begin
                @(negedge clock);
                total++;
                if (bus_show !== exp_bus) begin
                    bad++; $display("[TB] FAIL priority frame %0d bit %0d: bus_show=%b expected %b", fr, k, bus_show, exp_bus);
                end
                f1[FB-1-k] = bus_show;
            end
            total++;
            if (f1[FB-2 -: 4] !== 4'h0 || f1[FB-10 -: 64] !== 64'h0) begin
                bad++; $display("[TB] FAIL priority_fields frame %0d: sender=%h payload=%h expected 0 and 0", fr, f1[FB-2 -: 4], f1[FB-10 -: 64]);
            end
        end
        mod = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== 1'b1) begin
                bad++; $display("[TB] FAIL priority_idle cycle %0d: bus_show=%b expected 1", k, bus_show);
            end
        end
    endtask

    task automatic test_handover();
        data[0] = {$urandom, $urandom}; rx[0] = 4'h3; crc[0] = 4'h5;
        data[1] = 64'h0; rx[1] = 4'h2; crc[1] = 4'h1;
        mod = 16'h0001;
        for (int k = 0; k < FB; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== exp_bus) begin
                bad++; $display("[TB] FAIL handover_node1 bit %0d: bus_show=%b expected %b", k, bus_show, exp_bus);
            end
        end
        mod = 16'h0002;
        for (int k = 0; k < FB; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== exp_bus) begin
                bad++; $display("[TB] FAIL handover_node2 bit %0d: bus_show=%b expected %b", k, bus_show, exp_bus);
            end
            f2[FB-1-k] = bus_show;
        end
        total++;
        if (f2[FB-2 -: 8] !== 8'b0001_0010 || f2[EOF_BITS +: 4] !== 4'b0001) begin
            bad++; $display("[TB] FAIL handover_fields: addr=%b crc=%b expected 00010010 0001", f2[FB-2 -: 8], f2[EOF_BITS +: 4]);
        end
        mod = 16'h0000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== 1'b1) begin
                bad++; $display("[TB] FAIL handover_idle cycle %0d: bus_show=%b expected 1", k, bus_show);
            end
        end
    endtask

    task automatic test_snapshot();
        data[0] = 64'h1; rx[0] = 4'h1; crc[0] = 4'h1;
        mod = 16'h0001;
        for (int k = 0; k < FB; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== exp_bus) begin
                bad++; $display("[TB] FAIL snapshot_frame1 bit %0d: bus_show=%b expected %b", k, bus_show, exp_bus);
            end
            f1[FB-1-k] = bus_show;
            if (k == 30) data[0] = 64'hA5A5_A5A5_A5A5_A5A5;
        end
        for (int k = 0; k < FB; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== exp_bus) begin
                bad++; $display("[TB] FAIL snapshot_frame2 bit %0d: bus_show=%b expected %b", k, bus_show, exp_bus);
            end
            f2[FB-1-k] = bus_show;
            if (k == 0) mod = 16'h0000;
        end
        total++;
        if (f1[FB-10 -: 64] !== 64'h1) begin
            bad++; $display("[TB] FAIL snapshot_old_payload: got %h expected 1", f1[FB-10 -: 64]);
        end
        total++;
        if (f2[FB-10 -: 64] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            bad++; $display("[TB] FAIL snapshot_new_payload: got %h expected a5a5a5a5a5a5a5a5", f2[FB-10 -: 64]);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== 1'b1) begin
                bad++; $display("[TB] FAIL snapshot_idle cycle %0d: bus_show=%b expected 1", k, bus_show);
            end
        end
    endtask

    task automatic test_node16();
        logic [63:0] sent;
        sent = {$urandom, $urandom};
        data[15] = sent; rx[15] = 4'hF; crc[15] = 4'hA;
        mod = 16'h8000;
        for (int k = 0; k < FB; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== exp_bus) begin
                bad++; $display("[TB] FAIL node16 bit %0d: bus_show=%b expected %b", k, bus_show, exp_bus);
            end
            f1[FB-1-k] = bus_show;
            if (k == 0) mod = 16'h0000;
        end
        total++;
        if (f1[FB-2 -: 8] !== 8'hFF || f1[EOF_BITS +: 4] !== 4'hA || f1[FB-10 -: 64] !== sent) begin
            bad++; $display("[TB] FAIL node16_fields: addr=%h crc=%h payload=%h expected ff a %h",
                            f1[FB-2 -: 8], f1[EOF_BITS +: 4], f1[FB-10 -: 64], sent);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== 1'b1) begin
                bad++; $display("[TB] FAIL node16_idle cycle %0d: bus_show=%b expected 1", k, bus_show);
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 2500; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== exp_bus) begin
                bad++; $display("[TB] FAIL random cycle %0d: bus_show=%b expected %b", k, bus_show, exp_bus);
            end
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mod = 16'h0000;
                    1:       mod = 16'h0001 << $urandom_range(0, 15);
                    default: mod = 16'($urandom);
                endcase
            end
            n = $urandom_range(0, 15);
            data[n] = {$urandom, $urandom};
            rx[n]   = 4'($urandom);
            crc[n]  = 4'($urandom);
        end
        mod = 16'h0000;
        for (int k = 0; k < FB + 6; k++) begin
            @(negedge clock);
            total++;
            if (bus_show !== exp_bus) begin
                bad++; $display("[TB] FAIL random_drain cycle %0d: bus_show=%b expected %b", k, bus_show, exp_bus);
            end
        end
        total++;
        if (bus_show !== 1'b1) begin
            bad++; $display("[TB] FAIL random_final_idle: bus_show=%b expected 1", bus_show);
        end
    endtask

    // Scenarios run back to back; each one leaves the bus idle with mod = 0.
    initial begin
        $display("[TB] starting fpga bus bench");
        test_reset();
        test_single_node();
        test_priority();
        test_handover();
        test_snapshot();
        test_node16();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
